modulo_control_secded: RTL and testbench

MODULO_CONTROL_SECDED -- requirements
Module: modulo_control_secded

---
 rtl/modulo_secded_pkg.sv | 21 ++
 rtl/modulo_sindrome.sv | 15 +
 rtl/modulo_control_secded.sv | 123 ++++++++++++
 tb/tb_modulo_control_secded.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/modulo_secded_pkg.sv
// Shared types and word-layout constants for the SECDED receive controller.
// Layout: Hamming(7,4) bits in 0..6 plus an overall even-parity bit in 7.
package modulo_secded_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CORR = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int unsigned BIT_P1 = 0;
  localparam int unsigned BIT_P2 = 1;
  localparam int unsigned BIT_D1 = 2;
  localparam int unsigned BIT_P4 = 3;
  localparam int unsigned BIT_D2 = 4;
  localparam int unsigned BIT_D3 = 5;
  localparam int unsigned BIT_D4 = 6;
  localparam int unsigned BIT_G  = 7;

endpackage

// File: rtl/modulo_sindrome.sv
// Combinational Hamming syndrome {s4,s2,s1} and overall parity of a received word.
module modulo_sindrome
  import modulo_secded_pkg::*;
(
  input  logic [7:0] word,
  output logic [2:0] s,
  output logic       g
);

  assign s[0] = word[BIT_P1] ^ word[BIT_D1] ^ word[BIT_D2] ^ word[BIT_D4];
  assign s[1] = word[BIT_P2] ^ word[BIT_D1] ^ word[BIT_D3] ^ word[BIT_D4];
  assign s[2] = word[BIT_P4] ^ word[BIT_D2] ^ word[BIT_D3] ^ word[BIT_D4];
  assign g    = ^word;

endmodule

// File: rtl/modulo_control_secded.sv
// Four-state SECDED decode pipeline with valid/ready handshakes and
// saturating single/double error counters.
module modulo_control_secded
  import modulo_secded_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_word,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3:0]       data_out,
  output logic [7:0]       word_corr,
  output logic [2:0]       syndrome,
  output logic             err_single,
  output logic             err_double,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_r, state_next_s;
  logic [7:0] word_r;
  logic [2:0] syn_r;
  logic       g_r;
  logic [2:0] syn_s;
  logic       g_s;
  logic [7:0] corr_s;
  logic       single_s, double_s;

  modulo_sindrome u_sindrome (
    .word (word_r),
    .s    (syn_s),
    .g    (g_s)
  );

  // Rst gating keeps in_ready low during reset even though state already reads IDLE.
  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = (state_r == OUT);

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = in_valid ? CALC : IDLE;
      CALC:    state_next_s = CORR;
      CORR:    state_next_s = OUT;
      OUT:     state_next_s = out_ready ? IDLE : OUT;
      default: state_next_s = IDLE;
    endcase
  end

  // Classification and correction from the registered syndrome and parity.
  always_comb begin
    corr_s   = word_r;
    single_s = 1'b0;
    double_s = 1'b0;
    if (g_r) begin
      single_s = 1'b1;
      if (syn_r == 3'd0) begin
        corr_s[BIT_G] = ~word_r[BIT_G];
      end else begin
        corr_s[syn_r - 3'd1] = ~word_r[syn_r - 3'd1];
      end
    end else if (syn_r != 3'd0) begin
      double_s = 1'b1;
    end else begin
      single_s = 1'b0;
    end
  end

  // State and pipeline registers; results only change on CORR->OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      word_r     <= 8'h00;
      syn_r      <= 3'd0;
      g_r        <= 1'b0;
      word_corr  <= 8'h00;
      data_out   <= 4'h0;
      syndrome   <= 3'd0;
      err_single <= 1'b0;
      err_double <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_r == IDLE && in_valid) begin
        word_r <= in_word;
      end
      if (state_r == CALC) begin
        syn_r <= syn_s;
        g_r   <= g_s;
      end
      if (state_r == CORR) begin
        word_corr  <= corr_s;
        data_out   <= {corr_s[BIT_D4], corr_s[BIT_D3], corr_s[BIT_D2], corr_s[BIT_D1]};
        syndrome   <= syn_r;
        err_single <= single_s;
        err_double <= double_s;
      end
    end
  end

  // Saturating error counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (clr_cnt) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (state_r == CORR) begin
      if (single_s && cnt_single != CNT_MAX) cnt_single <= cnt_single + CNT_ONE;
      if (double_s && cnt_double != CNT_MAX) cnt_double <= cnt_double + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_modulo_control_secded.sv
// Directed table-driven bench: a default-width DUT and a 2-bit-counter DUT share stimulus.
module tb_modulo_control_secded;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, clr_cnt;
  logic [7:0] in_word;
  logic       in_ready, out_valid, err_single, err_double;
  logic [3:0] data_out;
  logic [7:0] word_corr, cnt_single, cnt_double;
  logic [2:0] syndrome;
  logic       in_ready2, out_valid2, err_single2, err_double2;
  logic [3:0] data_out2;
  logic [7:0] word_corr2;
  logic [2:0] syndrome2;
  logic [1:0] cnt_single2, cnt_double2;

  int checks = 0;
  int errors = 0;
  int exp_cs8 = 0, exp_cd8 = 0, exp_cs2 = 0, exp_cd2 = 0;

  always #5 clk = ~clk;

  modulo_control_secded #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .data_out(data_out), .word_corr(word_corr),
    .syndrome(syndrome), .err_single(err_single), .err_double(err_double), .clr_cnt(clr_cnt),
    .cnt_single(cnt_single), .cnt_double(cnt_double)
  );

  modulo_control_secded #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready2),
    .out_ready(out_ready), .out_valid(out_valid2), .data_out(data_out2), .word_corr(word_corr2),
    .syndrome(syndrome2), .err_single(err_single2), .err_double(err_double2), .clr_cnt(clr_cnt),
    .cnt_single(cnt_single2), .cnt_double(cnt_double2)
  );

  typedef struct {
    logic [7:0] word;
    logic [3:0] data;
    logic [7:0] corr;
    logic [2:0] syn;
    logic       es;
    logic       ed;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_data_out"}, {28'd0, data_out}, 32'd0);
    check({tag, "_word_corr"}, {24'd0, word_corr}, 32'd0);
    check({tag, "_syndrome"}, {29'd0, syndrome}, 32'd0);
    check({tag, "_flags"}, {30'd0, err_single, err_double}, 32'd0);
    check({tag, "_cnt8"}, {16'd0, cnt_single, cnt_double}, 32'd0);
    check({tag, "_cnt2"}, {28'd0, cnt_single2, cnt_double2}, 32'd0);
  endtask

  // Offer a word, scramble inputs after acceptance, and land in OUT with latency checks.
  task automatic send_word(input logic [7:0] w, input logic clr_at_corr);
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_word  = w;
    @(negedge clk);
    in_valid = 1'b0;
    in_word  = ~w;
    check("calc_out_valid", {31'd0, out_valid}, 32'd0);
    check("calc_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("corr_out_valid", {31'd0, out_valid}, 32'd0);
    clr_cnt = clr_at_corr;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic check_result(input vec_t v, input string tag);
    check({tag, "_data_out"}, {28'd0, data_out}, {28'd0, v.data});
    check({tag, "_word_corr"}, {24'd0, word_corr}, {24'd0, v.corr});
    check({tag, "_syndrome"}, {29'd0, syndrome}, {29'd0, v.syn});
    check({tag, "_flags"}, {30'd0, err_single, err_double}, {30'd0, v.es, v.ed});
    check({tag, "_dut2_word"}, {24'd0, word_corr2}, {24'd0, v.corr});
  endtask

  task automatic update_model(input vec_t v);
    if (v.es) begin
      exp_cs8 = (exp_cs8 < 255) ? exp_cs8 + 1 : 255;
      exp_cs2 = (exp_cs2 < 3) ? exp_cs2 + 1 : 3;
    end
    if (v.ed) begin
      exp_cd8 = (exp_cd8 < 255) ? exp_cd8 + 1 : 255;
      exp_cd2 = (exp_cd2 < 3) ? exp_cd2 + 1 : 3;
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_cnt_single"}, {24'd0, cnt_single}, exp_cs8);
    check({tag, "_cnt_double"}, {24'd0, cnt_double}, exp_cd8);
    check({tag, "_cnt_single2"}, {30'd0, cnt_single2}, exp_cs2);
    check({tag, "_cnt_double2"}, {30'd0, cnt_double2}, exp_cd2);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("released_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vec_t hv;
    //               word   data   corr   syn   es    ed
    tbl[0] = '{8'h55, 4'hB, 8'h55, 3'd0, 1'b0, 1'b0};
    tbl[1] = '{8'h45, 4'hB, 8'h55, 3'd5, 1'b1, 1'b0};
    tbl[2] = '{8'hD5, 4'hB, 8'h55, 3'd0, 1'b1, 1'b0};
    tbl[3] = '{8'h56, 4'hB, 8'h56, 3'd3, 1'b0, 1'b1};
    tbl[4] = '{8'h54, 4'hB, 8'h55, 3'd1, 1'b1, 1'b0};
    tbl[5] = '{8'h15, 4'hB, 8'h55, 3'd7, 1'b1, 1'b0};
    tbl[6] = '{8'h57, 4'hB, 8'h55, 3'd2, 1'b1, 1'b0};
    tbl[7] = '{8'h03, 4'h0, 8'h03, 3'd3, 1'b0, 1'b1};
    tbl[8] = '{8'h00, 4'h0, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[9] = '{8'hFF, 4'hF, 8'hFF, 3'd0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_word = 8'h00; out_ready = 1'b0; clr_cnt = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      send_word(tbl[i].word, 1'b0);
      update_model(tbl[i]);
      check_result(tbl[i], $sformatf("vec%0d", i));
      check_counts($sformatf("vec%0d", i));
      release_out();
    end

    // Stall in OUT: outputs hold, new words are ignored, and the word offered
    // on the OUT->IDLE edge is not taken.
    hv = tbl[3];
    send_word(hv.word, 1'b0);
    update_model(hv);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_word  = 8'h45;
      @(negedge clk);
      check_result(hv, $sformatf("hold%0d", c));
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    check_counts("hold");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("exit_out_valid", {31'd0, out_valid}, 32'd0);
    check("exit_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("no_accept_on_exit", {31'd0, in_ready}, 32'd1);

    // Clear coincides with a single-error increment: clear wins.
    send_word(8'h45, 1'b1);
    exp_cs8 = 0; exp_cd8 = 0; exp_cs2 = 0; exp_cd2 = 0;
    check_counts("clr_prio");
    release_out();

    // Narrow counter saturates at 3 after five single errors.
    for (int k = 0; k < 5; k++) begin
      send_word(8'h45, 1'b0);
      update_model(tbl[1]);
      release_out();
    end
    check_counts("sat");
    check("sat_value2", {30'd0, cnt_single2}, 32'd3);

    // Reset in CALC aborts the word in flight.
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = 8'h56;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_cs8 = 0; exp_cd8 = 0; exp_cs2 = 0; exp_cd2 = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
    send_word(8'h55, 1'b0);
    check_result(tbl[0], "post_abort");
    check_counts("post_abort");
    release_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
